isp_uart_host: RTL

ISP_UART_HOST -- requirements
Module: isp_uart_host

---
 rtl/isp_uart_host.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/isp_uart_host.sv
// isp_uart_host: drives an ISP debugger over 8N1 UART. Sends hex-encoded
// read/write command frames and parses the 8-byte reply into a response strobe.
module isp_uart_host #(
  parameter int UART_CLK_DIV   = 434,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int DIV_W = $clog2(UART_CLK_DIV + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(UART_CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(UART_CLK_DIV / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [63:0]      WR_DONE   = "wr done ";

  typedef enum logic [2:0] {INIT_TX, INIT_RX, IDLE, SEND, WAIT_RSP, RESP} state_t;

  function automatic logic [7:0] hex_enc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Returns {valid, nibble}; upper and lower case letters share the low nibble.
  function automatic logic [4:0] hex_dec(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return {1'b1, b[3:0]};
    if ((b >= 8'h61 && b <= 8'h66) || (b >= 8'h41 && b <= 8'h46)) return {1'b1, b[3:0] + 4'd9};
    return 5'h00;
  endfunction

  // ---------------- serializer ----------------
  logic             tx_busy_reg;
  logic [DIV_W-1:0] tx_div_reg;
  logic [3:0]       tx_bit_reg;
  logic [9:0]       tx_shift_reg;
  logic             tx_load;
  logic [7:0]       tx_char;
  logic             tx_last;
  logic             tx_free;

  // A new character may load on the final stop-bit cycle, giving gapless output.
  assign tx_last   = tx_busy_reg && (tx_div_reg == DIV_LAST) && (tx_bit_reg == 4'd9);
  assign tx_free   = !tx_busy_reg || tx_last;
  assign o_uart_tx = tx_busy_reg ? tx_shift_reg[0] : 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_busy_reg  <= 1'b0;
      tx_div_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '1;
    end else if (tx_load && tx_free) begin
      tx_busy_reg  <= 1'b1;
      tx_div_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= {1'b1, tx_char, 1'b0};
    end else if (tx_busy_reg) begin
      if (tx_div_reg == DIV_LAST) begin
        tx_div_reg <= '0;
        if (tx_bit_reg == 4'd9) begin
          tx_busy_reg <= 1'b0;
        end else begin
          tx_bit_reg   <= tx_bit_reg + 4'd1;
          tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
        end
      end else begin
        tx_div_reg <= tx_div_reg + DIV_W'(1);
      end
    end
  end

  // ---------------- deserializer ----------------
  logic             rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic             rx_active_reg;
  logic [DIV_W-1:0] rx_div_reg;
  logic [3:0]       rx_bit_reg;
  logic [7:0]       rx_shift_reg;
  logic             rx_valid_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_reg   <= 1'b1;
      rx_sync_reg   <= 1'b1;
      rx_prev_reg   <= 1'b1;
      rx_active_reg <= 1'b0;
      rx_div_reg    <= '0;
      rx_bit_reg    <= '0;
      rx_shift_reg  <= '0;
      rx_valid_reg  <= 1'b0;
    end else begin
      rx_meta_reg  <= i_uart_rx;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      rx_valid_reg <= 1'b0;
      if (!rx_active_reg) begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_active_reg <= 1'b1;
          rx_div_reg    <= '0;
          rx_bit_reg    <= '0;
        end
      end else if (rx_bit_reg == 4'd0) begin
        // Half-bit recheck rejects glitches that only look like a start bit.
        if (rx_div_reg == HALF_LAST) begin
          rx_div_reg <= '0;
          if (!rx_sync_reg) rx_bit_reg <= 4'd1;
          else rx_active_reg <= 1'b0;
        end else begin
          rx_div_reg <= rx_div_reg + DIV_W'(1);
        end
      end else if (rx_div_reg == DIV_LAST) begin
        rx_div_reg <= '0;
        if (rx_bit_reg == 4'd9) begin
          rx_active_reg <= 1'b0;
          rx_valid_reg  <= rx_sync_reg;
        end else begin
          rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
          rx_bit_reg   <= rx_bit_reg + 4'd1;
        end
      end else begin
        rx_div_reg <= rx_div_reg + DIV_W'(1);
      end
    end
  end

  // ---------------- control ----------------
  state_t          state_reg, state_next;
  logic [4:0]      idx_reg, idx_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic [TO_W-1:0] to_reg, to_next;
  logic [31:0]     acc_reg, acc_next;
  logic            err_reg, err_next;
  logic            write_reg, write_next;
  logic [31:0]     addr_reg, addr_next;
  logic [31:0]     wdata_reg, wdata_next;
  logic [31:0]     rsp_rdata_reg, rsp_rdata_next;
  logic            rsp_err_reg, rsp_err_next;
  logic [4:0]      frame_len;
  logic [4:0]      wdata_idx;
  logic [2:0]      addr_sel, wdata_sel;
  logic [4:0]      rx_dec;
  logic [7:0]      wr_exp;

  assign cmd_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= INIT_TX;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      to_reg        <= '0;
      acc_reg       <= '0;
      err_reg       <= 1'b0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      to_reg        <= to_next;
      acc_reg       <= acc_next;
      err_reg       <= err_next;
      write_reg     <= write_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    cnt_next       = cnt_reg;
    to_next        = to_reg;
    acc_next       = acc_reg;
    err_next       = err_reg;
    write_next     = write_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    tx_load        = 1'b0;
    tx_char        = 8'h0A;
    frame_len      = 5'd1;
    addr_sel       = ~idx_reg[2:0];
    wdata_idx      = idx_reg - 5'd9;
    wdata_sel      = ~wdata_idx[2:0];
    rx_dec         = hex_dec(rx_shift_reg);
    wr_exp         = WR_DONE[{~cnt_reg, 3'b000} +: 8];

    // Character index -> frame character; INIT_TX uses the default single newline.
    if (state_reg == SEND) begin
      frame_len = write_reg ? 5'd18 : 5'd9;
      if (idx_reg < 5'd8) tx_char = hex_enc(addr_reg[{addr_sel, 2'b00} +: 4]);
      else if (write_reg && idx_reg == 5'd8) tx_char = 8'h20;
      else if (write_reg && idx_reg < 5'd17) tx_char = hex_enc(wdata_reg[{wdata_sel, 2'b00} +: 4]);
    end

    case (state_reg)
      INIT_TX, SEND: begin
        if (idx_reg < frame_len) begin
          tx_load = 1'b1;
          if (tx_free) idx_next = idx_reg + 5'd1;
        end else if (tx_last) begin
          state_next = (state_reg == INIT_TX) ? INIT_RX : WAIT_RSP;
          cnt_next   = '0;
          to_next    = '0;
          acc_next   = '0;
          err_next   = 1'b0;
        end
      end
      INIT_RX: begin
        if (rx_valid_reg) begin
          cnt_next = cnt_reg + 3'd1;
          to_next  = '0;
          if (cnt_reg == 3'd7) state_next = IDLE;
        end else if (to_reg == TO_LAST) begin
          state_next = IDLE;
        end else begin
          to_next = to_reg + TO_W'(1);
        end
      end
      IDLE: begin
        if (cmd_valid) begin
          write_next = cmd_write;
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      WAIT_RSP: begin
        if (rx_valid_reg) begin
          to_next  = '0;
          cnt_next = cnt_reg + 3'd1;
          if (write_reg) err_next = err_reg | (rx_shift_reg != wr_exp);
          else if (rx_dec[4]) acc_next = {acc_reg[27:0], rx_dec[3:0]};
          else err_next = 1'b1;
          if (cnt_reg == 3'd7) begin
            state_next     = RESP;
            rsp_err_next   = err_next;
            rsp_rdata_next = (write_reg || err_next) ? 32'h0 : acc_next;
          end
        end else if (to_reg == TO_LAST) begin
          state_next     = RESP;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = 32'h0;
        end else begin
          to_next = to_reg + TO_W'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = INIT_TX;
    endcase
  end
endmodule
